// File: rtl/fp_divsqrt_reservation_ctrl.sv
// Per-lane FREE/RESERVED/BUSY/FINISHED occupancy control for the iterative FP div/sqrt core.
// Optional watchdog enabled by defining FP_DIVSQRT_WATCHDOG_EN.
module fp_divsqrt_reservation_ctrl #(
    parameter int unsigned ISSUE_WIDTH = 1,
    parameter int unsigned AL_IDX_W    = 6,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned WDOG_CYCLES = 64
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ISSUE_WIDTH-1:0]               acquire_i,
    input  logic [ISSUE_WIDTH-1:0][AL_IDX_W-1:0] acquire_ptr_i,
    input  logic [ISSUE_WIDTH-1:0]               req_i,
    input  logic [ISSUE_WIDTH-1:0]               stall_i,
    input  logic [ISSUE_WIDTH-1:0]               release_i,
    input  logic                                 flush_i,
    input  logic [AL_IDX_W-1:0]                  flush_ptr_i,
    input  logic [AL_IDX_W-1:0]                  head_ptr_i,
    output logic [ISSUE_WIDTH-1:0]               core_start_o,
    output logic [ISSUE_WIDTH-1:0]               core_kill_o,
    input  logic [ISSUE_WIDTH-1:0]               core_done_i,
    input  logic [ISSUE_WIDTH-1:0][DATA_W-1:0]   core_data_i,
    input  logic [ISSUE_WIDTH-1:0][4:0]          core_fflags_i,
    output logic [ISSUE_WIDTH-1:0]               free_o,
    output logic [ISSUE_WIDTH-1:0]               reserved_o,
    output logic [ISSUE_WIDTH-1:0]               busy_o,
    output logic [ISSUE_WIDTH-1:0]               finished_o,
    output logic [ISSUE_WIDTH-1:0][DATA_W-1:0]   data_o,
    output logic [ISSUE_WIDTH-1:0][4:0]          fflags_o,
    output logic [ISSUE_WIDTH-1:0]               wdog_err_o
);

    typedef enum logic [1:0] {StFree, StReserved, StBusy, StFinished} state_e;

    state_e                              state_q [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0][AL_IDX_W-1:0] ptr_q;
    logic [ISSUE_WIDTH-1:0][DATA_W-1:0]   data_q;
    logic [ISSUE_WIDTH-1:0][4:0]          fflags_q;
    logic [ISSUE_WIDTH-1:0]               flushed;
    logic [ISSUE_WIDTH-1:0]               wdog_fire;
    logic [AL_IDX_W-1:0]                  flush_age;

    // Ages are distances from the head; modular subtraction handles pointer wrap.
    assign flush_age = flush_ptr_i - head_ptr_i;

`ifdef FP_DIVSQRT_WATCHDOG_EN
    localparam int unsigned WdogW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    logic [ISSUE_WIDTH-1:0][WdogW-1:0] cnt_q;
    logic [ISSUE_WIDTH-1:0]            wdog_err_q;
    assign wdog_err_o = wdog_err_q;
`else
    assign wdog_err_o = '0;
`endif

    always_comb begin
        flushed      = '0;
        wdog_fire    = '0;
        core_start_o = '0;
        core_kill_o  = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            flushed[i] = flush_i && (state_q[i] != StFree) &&
                         ((ptr_q[i] - head_ptr_i) >= flush_age);
`ifdef FP_DIVSQRT_WATCHDOG_EN
            wdog_fire[i] = (state_q[i] == StBusy) && !flushed[i] && !core_done_i[i] &&
                           (cnt_q[i] == WdogW'(WDOG_CYCLES - 1));
`endif
            core_start_o[i] = (state_q[i] == StReserved) && !flushed[i] && !release_i[i] &&
                              req_i[i] && !stall_i[i];
            // A same-cycle done means the core already stopped; no kill needed.
            core_kill_o[i]  = ((state_q[i] == StBusy) && flushed[i] && !core_done_i[i]) ||
                              wdog_fire[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ISSUE_WIDTH; i++) state_q[i] <= StFree;
            ptr_q    <= '0;
            data_q   <= '0;
            fflags_q <= '0;
`ifdef FP_DIVSQRT_WATCHDOG_EN
            cnt_q      <= '0;
            wdog_err_q <= '0;
`endif
        end else begin
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                unique case (state_q[i])
                    StFree: begin
                        if (acquire_i[i]) begin
                            state_q[i] <= StReserved;
                            ptr_q[i]   <= acquire_ptr_i[i];
                        end
                    end
                    StReserved: begin
                        if (flushed[i] || release_i[i]) begin
                            state_q[i] <= StFree;
                        end else if (core_start_o[i]) begin
                            state_q[i] <= StBusy;
`ifdef FP_DIVSQRT_WATCHDOG_EN
                            cnt_q[i] <= '0;
`endif
                        end
                    end
                    StBusy: begin
                        if (flushed[i]) begin
                            state_q[i] <= StFree;
                        end else if (core_done_i[i]) begin
                            state_q[i]  <= StFinished;
                            data_q[i]   <= core_data_i[i];
                            fflags_q[i] <= core_fflags_i[i];
                        end else if (wdog_fire[i]) begin
                            state_q[i]  <= StFinished;
                            data_q[i]   <= '0;
                            fflags_q[i] <= '0;
`ifdef FP_DIVSQRT_WATCHDOG_EN
                            wdog_err_q[i] <= 1'b1;
`endif
                        end else begin
`ifdef FP_DIVSQRT_WATCHDOG_EN
                            cnt_q[i] <= cnt_q[i] + 1'b1;
`endif
                        end
                    end
                    StFinished: begin
                        if (flushed[i] || release_i[i]) state_q[i] <= StFree;
                    end
                    default: state_q[i] <= StFree;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            free_o[i]     = (state_q[i] == StFree);
            reserved_o[i] = (state_q[i] == StReserved);
            busy_o[i]     = (state_q[i] == StBusy);
            finished_o[i] = (state_q[i] == StFinished);
        end
    end

    assign data_o   = data_q;
    assign fflags_o = fflags_q;

endmodule

// File: tb/tb_fp_divsqrt_reservation_ctrl.sv
// Scoreboard bench for fp_divsqrt_reservation_ctrl (single lane, WDOG_CYCLES = 8).
module tb_fp_divsqrt_reservation_ctrl;

    localparam int FREE = 0, RES = 1, BUSY = 2, FIN = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [0:0]      acquire = '0, req = '0, stall = '0, rel = '0, done = '0;
    logic [0:0][5:0] acq_ptr = '0;
    logic            flush = 1'b0;
    logic [5:0]      flush_ptr = '0, head_ptr = '0;
    logic [0:0][63:0] core_data = '0;
    logic [0:0][4:0]  core_ff = '0;
    logic [0:0]      start, kill, free_s, res_s, busy_s, fin_s, wdog;
    logic [0:0][63:0] data;
    logic [0:0][4:0]  ff;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        int          st;
        bit          start;
        bit          kill;
        logic [63:0] d;
        logic [4:0]  f;
        bit          w;
    } exp_t;
    exp_t sb[$];

    fp_divsqrt_reservation_ctrl #(
        .ISSUE_WIDTH(1), .AL_IDX_W(6), .DATA_W(64), .WDOG_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .acquire_i(acquire), .acquire_ptr_i(acq_ptr), .req_i(req), .stall_i(stall),
        .release_i(rel), .flush_i(flush), .flush_ptr_i(flush_ptr), .head_ptr_i(head_ptr),
        .core_start_o(start), .core_kill_o(kill), .core_done_i(done),
        .core_data_i(core_data), .core_fflags_i(core_ff),
        .free_o(free_s), .reserved_o(res_s), .busy_o(busy_s), .finished_o(fin_s),
        .data_o(data), .fflags_o(ff), .wdog_err_o(wdog)
    );

    always #5 clk = ~clk;

    // Monitor: one expected snapshot per driven cycle, compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                logic [75:0] act, expv;
                e    = sb.pop_front();
                act  = {free_s[0], res_s[0], busy_s[0], fin_s[0], start[0], kill[0],
                        data[0], ff[0], wdog[0]};
                expv = {e.st == FREE, e.st == RES, e.st == BUSY, e.st == FIN, e.start, e.kill,
                        e.d, e.f, e.w};
                checks++;
                if (act !== expv) begin
                    errors++;
                    $display("FAIL %s: got fr/rs/bs/fn/st/kl=%b data=%h ff=%h wd=%b, want %b %h %h %b",
                             e.nm, act[75:70], act[69:6], act[5:1], act[0],
                             expv[75:70], expv[69:6], expv[5:1], expv[0]);
                end
            end
        end
    end

    task automatic tick(input string nm, input int st, input bit s, input bit k,
                        input logic [63:0] d, input logic [4:0] f, input bit w);
        exp_t e;
        e.nm = nm; e.st = st; e.start = s; e.kill = k; e.d = d; e.f = f; e.w = w;
        sb.push_back(e);
        @(posedge clk);
        #1;
        acquire = '0; req = '0; stall = '0; rel = '0; done = '0; flush = 1'b0;
    endtask

    localparam logic [63:0] D1 = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] D2 = 64'h0000_0000_0000_AAAA;

    initial begin
        @(posedge clk); #1;
        tick("reset", FREE, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Basic flow with stalled request
        acquire = 1; acq_ptr[0] = 6'd5;       tick("acq5", FREE, 0, 0, 0, 0, 0);
        req = 1; stall = 1;                   tick("stall1", RES, 0, 0, 0, 0, 0);
        req = 1; stall = 1;                   tick("stall2", RES, 0, 0, 0, 0, 0);
        req = 1;                              tick("start", RES, 1, 0, 0, 0, 0);
                                              tick("busy", BUSY, 0, 0, 0, 0, 0);
        done = 1; core_data[0] = D1; core_ff[0] = 5'h01;
                                              tick("done", BUSY, 0, 0, 0, 0, 0);
        core_data[0] = '0; core_ff[0] = '0;
                                              tick("fin", FIN, 0, 0, D1, 5'h01, 0);
                                              tick("fin_hold", FIN, 0, 0, D1, 5'h01, 0);
        rel = 1;                              tick("release", FIN, 0, 0, D1, 5'h01, 0);
                                              tick("freed", FREE, 0, 0, D1, 5'h01, 0);

        // Flush age compare across pointer wrap
        head_ptr = 6'd60;
        acquire = 1; acq_ptr[0] = 6'd2;       tick("acq2", FREE, 0, 0, D1, 5'h01, 0);
        req = 1;                              tick("start2", RES, 1, 0, D1, 5'h01, 0);
                                              tick("busy2", BUSY, 0, 0, D1, 5'h01, 0);
        flush = 1; flush_ptr = 6'd3;          tick("flush_younger", BUSY, 0, 0, D1, 5'h01, 0);
        flush = 1; flush_ptr = 6'd63;         tick("flush_kill", BUSY, 0, 1, D1, 5'h01, 0);
                                              tick("flushed_free", FREE, 0, 0, D1, 5'h01, 0);
        head_ptr = 6'd0;

        // done + flush at equal age: discard, no kill
        acquire = 1; acq_ptr[0] = 6'd10;      tick("acq10", FREE, 0, 0, D1, 5'h01, 0);
        req = 1;                              tick("start3", RES, 1, 0, D1, 5'h01, 0);
        done = 1; core_data[0] = 64'h1234; core_ff[0] = 5'h1f; flush = 1; flush_ptr = 6'd10;
                                              tick("done_flush", BUSY, 0, 0, D1, 5'h01, 0);
        core_data[0] = '0; core_ff[0] = '0;
                                              tick("discarded", FREE, 0, 0, D1, 5'h01, 0);
        acquire = 1; acq_ptr[0] = 6'd11;      tick("acq11", FREE, 0, 0, D1, 5'h01, 0);
        rel = 1; req = 1;                     tick("rel_req", RES, 0, 0, D1, 5'h01, 0);
                                              tick("cancelled", FREE, 0, 0, D1, 5'h01, 0);

        // acquire ignored while FINISHED; latched pointer must stay 20
        acquire = 1; acq_ptr[0] = 6'd20;      tick("acq20", FREE, 0, 0, D1, 5'h01, 0);
        req = 1;                              tick("start4", RES, 1, 0, D1, 5'h01, 0);
        done = 1; core_data[0] = D2; core_ff[0] = 5'h02;
                                              tick("done4", BUSY, 0, 0, D1, 5'h01, 0);
        acquire = 1; acq_ptr[0] = 6'd40;      tick("acq_in_fin", FIN, 0, 0, D2, 5'h02, 0);
        flush = 1; flush_ptr = 6'd30;         tick("flush_older", FIN, 0, 0, D2, 5'h02, 0);
                                              tick("fin_kept", FIN, 0, 0, D2, 5'h02, 0);
        rel = 1; acquire = 1; acq_ptr[0] = 6'd7;
                                              tick("rel_acq", FIN, 0, 0, D2, 5'h02, 0);
                                              tick("acq_dropped", FREE, 0, 0, D2, 5'h02, 0);
        acquire = 1; flush = 1; flush_ptr = 6'd7;
                                              tick("acq_flush", FREE, 0, 0, D2, 5'h02, 0);
                                              tick("acq_kept", RES, 0, 0, D2, 5'h02, 0);
        rel = 1;                              tick("rel_res", RES, 0, 0, D2, 5'h02, 0);
                                              tick("free5", FREE, 0, 0, D2, 5'h02, 0);

        // Async reset while BUSY
        acquire = 1; acq_ptr[0] = 6'd1;       tick("acq1", FREE, 0, 0, D2, 5'h02, 0);
        req = 1;                              tick("start5", RES, 1, 0, D2, 5'h02, 0);
                                              tick("busy5", BUSY, 0, 0, D2, 5'h02, 0);
        rst_n = 1'b0;                         tick("rst_busy", FREE, 0, 0, 0, 0, 0);
        rst_n = 1'b1;                         tick("post_rst", FREE, 0, 0, 0, 0, 0);

        // Core never finishes
        acquire = 1; acq_ptr[0] = 6'd2;       tick("acq_wd", FREE, 0, 0, 0, 0, 0);
        req = 1;                              tick("start_wd", RES, 1, 0, 0, 0, 0);
`ifdef FP_DIVSQRT_WATCHDOG_EN
        for (int c = 1; c < 8; c++)           tick("wd_busy", BUSY, 0, 0, 0, 0, 0);
                                              tick("wd_kill", BUSY, 0, 1, 0, 0, 0);
                                              tick("wd_fin", FIN, 0, 0, 0, 0, 1);
        rel = 1;                              tick("wd_rel", FIN, 0, 0, 0, 0, 1);
                                              tick("wd_sticky", FREE, 0, 0, 0, 0, 1);
`else
        for (int c = 0; c < 12; c++)          tick("no_wd_busy", BUSY, 0, 0, 0, 0, 0);
`endif

        for (int c = 0; c < 10 && sb.size() > 0; c++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
